// File: rtl/mult_pkg.sv
// Shared definitions for the sequential Booth multiplier.
//   mult_state_t       : controller state (IDLE, RUN, DONE)
//   MULT_WIDTH_DEFAULT : default operand width
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  localparam int MULT_WIDTH_DEFAULT = 32;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration, purely combinational.
// Ports:
//   acc_i, q_i, q1_i : current {acc, q, q_1} state
//   m_i              : extended multiplicand
//   acc_o, q_o, q1_o : state after add/subtract and arithmetic right shift
// N is the extended operand width (WIDTH+1 in the multiplier).
module booth_step #(
  parameter int N = 33
) (
  input  logic signed [N-1:0] acc_i,
  input  logic signed [N-1:0] q_i,
  input  logic                q1_i,
  input  logic signed [N-1:0] m_i,
  output logic signed [N-1:0] acc_o,
  output logic signed [N-1:0] q_o,
  output logic                q1_o
);

  logic signed [N-1:0] sum;

  always_comb begin
    sum = acc_i;
    unique case ({q_i[0], q1_i})
      2'b01:   sum = acc_i + m_i;
      2'b10:   sum = acc_i - m_i;
      default: sum = acc_i;
    endcase
  end

  // Arithmetic shift of the concatenation {sum, q, q_1} right by one.
  assign acc_o = {sum[N-1], sum[N-1:1]};
  assign q_o   = {sum[0], q_i[N-1:1]};
  assign q1_o  = q_i[0];

endmodule

// File: rtl/seq_booth_multiplier.sv
// Iterative radix-2 Booth multiplier, one product per WIDTH+2 cycles.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start         : request a multiply (accepted when not busy)
//   is_signed     : 1 = two's-complement operands, 0 = unsigned
//   a, b          : multiplicand / multiplier, sampled on accept
//   busy          : operation in progress, start ignored
//   done          : one-cycle pulse, p valid from this cycle on
//   p             : 2*WIDTH product, held until the next result or reset
// Operands are extended to WIDTH+1 bits so a single signed Booth datapath
// covers both modes; WIDTH+1 steps are therefore needed per product.
module seq_booth_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);

  localparam int EW    = WIDTH + 1;
  localparam int CNT_W = $clog2(WIDTH + 1);

  mult_state_t         state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic signed [EW-1:0] acc_q, acc_d;
  logic signed [EW-1:0] q_q, q_d;
  logic signed [EW-1:0] m_q, m_d;
  logic                q1_q, q1_d;
  logic [2*WIDTH-1:0]  p_q, p_d;

  logic signed [EW-1:0] a_ext, b_ext;
  logic signed [EW-1:0] acc_nx, q_nx;
  logic                 q1_nx;

  assign a_ext = is_signed ? {a[WIDTH-1], a} : {1'b0, a};
  assign b_ext = is_signed ? {b[WIDTH-1], b} : {1'b0, b};

  booth_step #(.N(EW)) u_step (
    .acc_i (acc_q),
    .q_i   (q_q),
    .q1_i  (q1_q),
    .m_i   (m_q),
    .acc_o (acc_nx),
    .q_o   (q_nx),
    .q1_o  (q1_nx)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    q_d     = q_q;
    q1_d    = q1_q;
    m_d     = m_q;
    p_d     = p_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = CNT_W'(WIDTH);
          acc_d   = '0;
          q_d     = b_ext;
          q1_d    = 1'b0;
          m_d     = a_ext;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d = acc_nx;
        q_d   = q_nx;
        q1_d  = q1_nx;
        if (cnt_q == '0) begin
          state_d = DONE;
          // Low 2*WIDTH bits of {acc, q}; the top two acc bits are only
          // sign copies of the (WIDTH+1)-bit operand product.
          p_d     = {acc_nx[WIDTH-2:0], q_nx};
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      m_q     <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      m_q     <= m_d;
      p_q     <= p_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign p    = p_q;

endmodule

// File: tb/tb_seq_booth_multiplier.sv
module tb_seq_booth_multiplier;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           is_signed = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] p;

  always #5 clk = ~clk;

  seq_booth_multiplier #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .p         (p)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  // Full product of the operands interpreted per mode, wrapped to 64 bits.
  function automatic logic [63:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic s);
    longint ex, ey;
    ex = s ? longint'($signed(x)) : longint'({32'b0, x});
    ey = s ? longint'($signed(y)) : longint'({32'b0, y});
    return 64'(ex * ey);
  endfunction

  // Behavioural timeline: an accepted request yields its product after
  // WIDTH+1 busy cycles, followed by a single done cycle.
  int          m_cnt = 0;
  bit          m_done = 1'b0;
  logic [63:0] m_p = '0;
  logic [63:0] m_pend = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
      m_p    <= '0;
    end else if (m_cnt > 0) begin
      m_cnt  <= m_cnt - 1;
      m_done <= (m_cnt == 1);
      if (m_cnt == 1) m_p <= m_pend;
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_pend <= ref_mul(a, b, is_signed);
        m_cnt  <= W + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 64'(busy), 64'(m_cnt > 0));
      check("done", 64'(done), 64'(m_done));
      check("p", p, m_p);
    end
  end

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    a = x; b = y; is_signed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom; is_signed = 1'($urandom_range(0, 1));
  endtask

  // Waits (bounded) for done; n0 = negedges already elapsed since issue began.
  task automatic await_done(input logic [63:0] exp, input int n0, input string name);
    int n;
    n = n0;
    while (done !== 1'b1 && n < W + 10) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: no done after %0d cycles, expected done at %0d", name, n, W + 2);
    end else begin
      check({name, "_latency"}, 64'(n), 64'(W + 2));
      check({name, "_p"}, p, exp);
      check({name, "_model"}, m_p, exp);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic         rs;
    int           k, seen;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_p", p, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(32'd5, 32'd7, 1'b1);                 await_done(64'h23, 1, "s_5x7");
    issue(32'd7, 32'hFFFF_FFF7, 1'b1);         await_done(64'hFFFF_FFFF_FFFF_FFC1, 1, "s_7xm9");
    issue(32'hFFFF_FFF7, 32'hFFFF_FFDE, 1'b1); await_done(64'h132, 1, "s_m9xm34");
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0); await_done(64'hFFFF_FFFE_0000_0001, 1, "u_ones");
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); await_done(64'h1, 1, "s_ones");
    issue(32'h8000_0000, 32'h8000_0000, 1'b1); await_done(64'h4000_0000_0000_0000, 1, "s_min");
    issue(32'h8000_0000, 32'h8000_0000, 1'b0); await_done(64'h4000_0000_0000_0000, 1, "u_min");
    repeat (2) @(negedge clk);

    // start while busy is dropped
    issue(32'd5, 32'd7, 1'b1);
    repeat (4) @(negedge clk);
    a = 32'd3; b = 32'd3; is_signed = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    await_done(64'd35, 6, "ignore");

    // back-to-back from the done cycle
    issue(32'd10, 32'd6, 1'b1);
    await_done(64'd60, 1, "b2b");
    @(negedge clk);

    // reset in the middle of an operation
    issue(32'd5, 32'd7, 1'b1);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_p", p, 64'd0);
    rst = 1'b0;
    seen = 0;
    repeat (W + 8) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    check("abort_no_done", 64'(seen), 64'd0);
    issue(32'd5, 32'd7, 1'b1);
    await_done(64'd35, 1, "after_abort");
    @(negedge clk);

    // reset and start together: start is dropped
    rst = 1'b1; start = 1'b1; a = 32'd5; b = 32'd7; is_signed = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_start_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("rst_start_idle", 64'(busy), 64'd0);

    // randomized operations, random gaps, spurious starts while busy
    for (int i = 0; i < 150; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      if (i % 10 == 0) ra = (i % 20 == 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
      issue(ra, rb, rs);
      if ($urandom_range(0, 9) < 3) begin
        k = $urandom_range(1, 20);
        repeat (k - 1) @(negedge clk);
        a = $urandom; b = $urandom; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        await_done(ref_mul(ra, rb, rs), 1 + k, "rnd_spurious");
      end else begin
        await_done(ref_mul(ra, rb, rs), 1, "rnd");
      end
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
